// File: rtl/fp_divider_if.sv
// Handshake and operand/result bundle for the iterative floating-point divider.
interface fp_divider_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int N = 1 + EXP_W + MAN_W;

    logic         start;
    logic [N-1:0] in_data_A;
    logic [N-1:0] in_data_B;
    logic [N-1:0] out_data;
    logic         busy;
    logic         done;
    logic         overflow_flag;
    logic         underflow_flag;
    logic         div_by_zero_flag;

    modport master (
        output start, in_data_A, in_data_B,
        input  out_data, busy, done, overflow_flag, underflow_flag, div_by_zero_flag
    );

    modport slave (
        input  start, in_data_A, in_data_B,
        output out_data, busy, done, overflow_flag, underflow_flag, div_by_zero_flag
    );
endinterface

// File: rtl/fp_divider.sv
// Iterative IEEE-754 divider, one restoring quotient bit per clock, start/busy/done handshake.
// Optional feature macro FP_DIV_ROUND_NEAREST_EN selects round-to-nearest-even (default truncates).
module fp_divider #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic           clk,
    input  logic           rst_n,
    fp_divider_if.slave    bus
);
    localparam int N    = 1 + EXP_W + MAN_W;
    localparam int BIAS = 2**(EXP_W-1) - 1;
    localparam int EMAX = 2**EXP_W - 1;
    localparam int QW   = MAN_W + 3;
    localparam int RW   = MAN_W + 2;
    localparam int EW   = EXP_W + 2;
    localparam int CW   = $clog2(QW);

    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_DIVIDE, S_NORM, S_DONE} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_busy, r_done, r_ovf, r_unf, r_dbz;
    logic [N-1:0]    r_out;

    logic [N-1:0]    r_a, r_b, r_spec_val;
    logic            r_spec, r_spec_dbz;
    logic [QW-1:0]   r_q;
    logic [RW-1:0]   r_rem;

    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_ma, w_mb;
    logic             w_sign, w_zero_a, w_zero_b, w_inf_a, w_inf_b, w_nan_a, w_nan_b;
    logic             w_spec, w_spec_dbz;
    logic [N-1:0]     w_spec_val;
    logic [RW-1:0]    w_div, w_diff, w_rem_nxt;
    logic             w_qbit;
    logic signed [EW-1:0] w_e, w_e_r;
    logic [MAN_W-1:0] w_mant, w_mant_r;
    logic [N-1:0]     w_res;
    logic             w_ovf, w_unf, w_dbz;

`ifdef FP_DIV_ROUND_NEAREST_EN
    logic             w_guard, w_sticky, w_carry;

    function automatic logic [MAN_W:0] round_rne(input logic [MAN_W-1:0] mant,
                                                 input logic guard, input logic sticky);
        return {1'b0, mant} + (MAN_W+1)'(guard & (sticky | mant[0]));
    endfunction
`endif

    assign w_sign   = r_a[N-1] ^ r_b[N-1];
    assign w_ea     = r_a[N-2:MAN_W];
    assign w_eb     = r_b[N-2:MAN_W];
    assign w_ma     = r_a[MAN_W-1:0];
    assign w_mb     = r_b[MAN_W-1:0];
    assign w_zero_a = (w_ea == '0);
    assign w_zero_b = (w_eb == '0);
    assign w_inf_a  = (&w_ea) && (w_ma == '0);
    assign w_inf_b  = (&w_eb) && (w_mb == '0);
    assign w_nan_a  = (&w_ea) && (w_ma != '0);
    assign w_nan_b  = (&w_eb) && (w_mb != '0);

    always_comb begin
        w_spec     = 1'b1;
        w_spec_dbz = 1'b0;
        w_spec_val = {w_sign, {(N-1){1'b0}}};
        if (w_nan_a || w_nan_b || (w_zero_a && w_zero_b) || (w_inf_a && w_inf_b)) begin
            w_spec_val = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        end else if (w_zero_b && !w_inf_a) begin
            w_spec_val = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_spec_dbz = 1'b1;
        end else if (w_inf_a) begin
            w_spec_val = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (!(w_inf_b || w_zero_a)) begin
            w_spec = 1'b0;
        end
    end

    // Restoring step: remainder stays below 2*divisor, so the shift never loses a set bit.
    assign w_div     = {2'b01, w_mb};
    assign w_qbit    = (r_rem >= w_div);
    assign w_diff    = r_rem - w_div;
    assign w_rem_nxt = (w_qbit ? w_diff : r_rem) << 1;

    always_comb begin
        w_e = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + $signed(EW'(BIAS));
        if (r_q[QW-1]) begin
            w_mant = r_q[QW-2:2];
        end else begin
            w_mant = r_q[MAN_W:1];
            w_e    = w_e - $signed(EW'(1));
        end
`ifdef FP_DIV_ROUND_NEAREST_EN
        w_guard  = r_q[QW-1] ? r_q[1] : r_q[0];
        w_sticky = (r_rem != '0) | (r_q[QW-1] & r_q[0]);
        {w_carry, w_mant_r} = round_rne(w_mant, w_guard, w_sticky);
        w_e_r = w_e + $signed(EW'(w_carry));
`else
        w_mant_r = w_mant;
        w_e_r    = w_e;
`endif
        w_ovf = 1'b0;
        w_unf = 1'b0;
        w_dbz = 1'b0;
        if (r_spec) begin
            w_res = r_spec_val;
            w_dbz = r_spec_dbz;
        end else if (w_e_r >= $signed(EW'(EMAX))) begin
            w_res = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_ovf = 1'b1;
        end else if (w_e_r <= $signed(EW'(0))) begin
            w_res = {w_sign, {(N-1){1'b0}}};
            w_unf = 1'b1;
        end else begin
            w_res = {w_sign, w_e_r[EXP_W-1:0], w_mant_r};
        end
    end

    // Datapath: no reset, only qualified by the control state.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && bus.start) begin
            r_a <= bus.in_data_A;
            r_b <= bus.in_data_B;
        end
        if (r_state == S_UNPACK) begin
            r_spec     <= w_spec;
            r_spec_val <= w_spec_val;
            r_spec_dbz <= w_spec_dbz;
            r_rem      <= {2'b01, w_ma};
            r_q        <= '0;
        end
        if (r_state == S_DIVIDE) begin
            r_rem <= w_rem_nxt;
            r_q   <= {r_q[QW-2:0], w_qbit};
        end
    end

    // Specials bypass DIVIDE but still pass through NORM, so every result is registered on one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_out   <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state <= S_UNPACK;
                        r_busy  <= 1'b1;
                        r_ovf   <= 1'b0;
                        r_unf   <= 1'b0;
                        r_dbz   <= 1'b0;
                    end
                end
                S_UNPACK: begin
                    r_cnt   <= CW'(QW-1);
                    r_state <= w_spec ? S_NORM : S_DIVIDE;
                end
                S_DIVIDE: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) r_state <= S_NORM;
                end
                S_NORM: begin
                    r_out   <= w_res;
                    r_ovf   <= w_ovf;
                    r_unf   <= w_unf;
                    r_dbz   <= w_dbz;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.out_data         = r_out;
    assign bus.busy             = r_busy;
    assign bus.done             = r_done;
    assign bus.overflow_flag    = r_ovf;
    assign bus.underflow_flag   = r_unf;
    assign bus.div_by_zero_flag = r_dbz;
endmodule

// File: tb/tb_fp_divider.sv
// Directed bench for fp_divider: hand-computed quotients, flags, latency, reset abort.
module tb_fp_divider;
    logic clk;
    logic rst_n;
    int   n_total;
    int   n_fail;

    fp_divider_if #(.EXP_W(8), .MAN_W(23)) bus ();

    fp_divider #(.EXP_W(8), .MAN_W(23)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Flags are compared as {overflow, underflow, div_by_zero}.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_out, input logic [2:0] exp_flags,
                          input int exp_lat, input bit poke);
        int cyc;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.in_data_A = a;
        bus.in_data_B = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc = 0;
        while (cyc < 60) begin
            @(posedge clk);
            cyc++;
            #1;
            if (poke && cyc == 5) begin
                bus.start     = 1'b1;
                bus.in_data_A = 32'h3F800000;
                bus.in_data_B = 32'h3F800000;
            end
            if (poke && cyc == 6) bus.start = 1'b0;
            if (bus.done) break;
        end
        check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_out"}, bus.out_data, exp_out);
        check({tag, "_flags"}, {29'd0, bus.overflow_flag, bus.underflow_flag, bus.div_by_zero_flag},
              {29'd0, exp_flags});
        check({tag, "_busy_at_done"}, {30'd0, bus.busy, bus.done}, 32'd3);
        @(posedge clk);
        #1;
        check({tag, "_idle_after"}, {30'd0, bus.busy, bus.done}, 32'd0);
    endtask

    initial begin
        int pulses;
        logic [31:0] third;
        n_total = 0;
        n_fail  = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.in_data_A = '0;
        bus.in_data_B = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", bus.out_data, 32'h0);
        check("reset_ctrl", {27'd0, bus.busy, bus.done, bus.overflow_flag, bus.underflow_flag,
              bus.div_by_zero_flag}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef FP_DIV_ROUND_NEAREST_EN
        third = 32'h3EAAAAAB;
`else
        third = 32'h3EAAAAAA;
`endif
        run_op("six_by_two",  32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 28, 1'b1);
        run_op("one_third",   32'h3F800000, 32'h40400000, third,        3'b000, 28, 1'b0);
        run_op("neg_six",     32'hC0C00000, 32'h40000000, 32'hC0400000, 3'b000, 28, 1'b0);
        run_op("div_zero",    32'h3F800000, 32'h00000000, 32'h7F800000, 3'b001, 2,  1'b0);
        run_op("overflow",    32'h7F000000, 32'h3E800000, 32'h7F800000, 3'b100, 28, 1'b0);
        run_op("underflow",   32'h00800000, 32'h40000000, 32'h00000000, 3'b010, 28, 1'b0);
        run_op("zero_zero",   32'h00000000, 32'h00000000, 32'h7FC00000, 3'b000, 2,  1'b0);
        run_op("inf_inf",     32'h7F800000, 32'h7F800000, 32'h7FC00000, 3'b000, 2,  1'b0);
        run_op("inf_by_zero", 32'hFF800000, 32'h00000000, 32'hFF800000, 3'b000, 2,  1'b0);
        run_op("zero_by_neg", 32'h00000000, 32'hC0000000, 32'h80000000, 3'b000, 2,  1'b0);

        // Abort an operation with reset partway through the divide loop.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.in_data_A = 32'h40C00000;
        bus.in_data_B = 32'h40000000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out", bus.out_data, 32'h0);
        check("abort_ctrl", {27'd0, bus.busy, bus.done, bus.overflow_flag, bus.underflow_flag,
              bus.div_by_zero_flag}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        run_op("restart", 32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 28, 1'b0);

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end
endmodule
